// File: rtl/demux_1to2_32bit_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer:
// slot state encoding and default widths.
package demux_1to2_32bit_reg_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot_32bit.sv
// One-entry output slot: holding register, valid state, local ready term
// and a saturating count of completed output handshakes.
module demux_slot_32bit
    import demux_1to2_32bit_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              slot_ready,
    output logic [CNT_W-1:0]  cnt
);

    slot_state_e state;
    logic        drain;

    assign valid      = (state == SLOT_FULL);
    assign drain      = valid && ready;
    // A full slot can still take a word in the same cycle it is being drained.
    assign slot_ready = !valid || ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            dout  <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                state <= SLOT_FULL;
                dout  <= din;
            end else if (drain) begin
                state <= SLOT_EMPTY;
            end

            if (drain && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/demux_1to2_32bit_reg.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream to slot A or B
// by a per-word select bit; only the selected slot can stall the input.
module demux_1to2_32bit_reg
    import demux_1to2_32bit_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] inData,
    input  logic              inSel,
    input  logic              inValid,
    output logic              inReady,
    output logic [DATA_W-1:0] outAData,
    output logic              outAValid,
    input  logic              outAReady,
    output logic [DATA_W-1:0] outBData,
    output logic              outBValid,
    input  logic              outBReady,
    output logic [CNT_W-1:0]  cntA,
    output logic [CNT_W-1:0]  cntB
);

    logic a_ready;
    logic b_ready;
    logic accept;

    assign inReady = inSel ? b_ready : a_ready;
    assign accept  = inValid && inReady;

    demux_slot_32bit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot_a (
        .clk        (Clk),
        .rst        (Rst),
        .load       (accept && !inSel),
        .din        (inData),
        .ready      (outAReady),
        .dout       (outAData),
        .valid      (outAValid),
        .slot_ready (a_ready),
        .cnt        (cntA)
    );

    demux_slot_32bit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot_b (
        .clk        (Clk),
        .rst        (Rst),
        .load       (accept && inSel),
        .din        (inData),
        .ready      (outBReady),
        .dout       (outBData),
        .valid      (outBValid),
        .slot_ready (b_ready),
        .cnt        (cntB)
    );

endmodule

// File: tb/tb_demux_1to2_32bit_reg.sv
// Bench for demux_1to2_32bit_reg: directed scenarios plus random traffic
// against a per-output queue model with saturating counters.
module tb_demux_1to2_32bit_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [DATA_W-1:0] inData = '0;
    logic              inSel = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [DATA_W-1:0] outAData;
    logic              outAValid;
    logic              outAReady = 1'b0;
    logic [DATA_W-1:0] outBData;
    logic              outBValid;
    logic              outBReady = 1'b0;
    logic [CNT_W-1:0]  cntA;
    logic [CNT_W-1:0]  cntB;

    int assertions = 0;
    int failures   = 0;

    // Reference model: words waiting at each output, oldest first, plus counts.
    logic [DATA_W-1:0] q_a[$];
    logic [DATA_W-1:0] q_b[$];
    int                m_cnt_a = 0;
    int                m_cnt_b = 0;

    logic rdy_obs;
    logic rdy_exp;

    always #5 Clk = ~Clk;

    demux_1to2_32bit_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .inData    (inData),
        .inSel     (inSel),
        .inValid   (inValid),
        .inReady   (inReady),
        .outAData  (outAData),
        .outAValid (outAValid),
        .outAReady (outAReady),
        .outBData  (outBData),
        .outBValid (outBValid),
        .outBReady (outBReady),
        .cntA      (cntA),
        .cntB      (cntB)
    );

    // Observable state: data is only meaningful while its slot is valid.
    function automatic logic [73:0] model_snap();
        logic va, vb;
        va = (q_a.size() != 0);
        vb = (q_b.size() != 0);
        return {va, va ? q_a[0] : 32'h0, vb, vb ? q_b[0] : 32'h0,
                CNT_W'(m_cnt_a), CNT_W'(m_cnt_b)};
    endfunction

    function automatic logic [73:0] dut_snap();
        return {outAValid, outAValid ? outAData : 32'h0,
                outBValid, outBValid ? outBData : 32'h0, cntA, cntB};
    endfunction

    // One clock cycle: drive, sample inReady, advance the model at the edge.
    task automatic cycle(input logic rst, input logic [DATA_W-1:0] d, input logic s,
                         input logic v, input logic ra, input logic rb);
        logic drain_a, drain_b, acc;
        @(negedge Clk);
        Rst = rst; inData = d; inSel = s; inValid = v; outAReady = ra; outBReady = rb;
        #1;
        rdy_obs = inReady;
        rdy_exp = s ? (q_b.size() == 0 || rb) : (q_a.size() == 0 || ra);
        drain_a = (q_a.size() != 0) && ra;
        drain_b = (q_b.size() != 0) && rb;
        acc     = v && rdy_exp;
        @(posedge Clk);
        if (rst) begin
            q_a.delete(); q_b.delete();
            m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (drain_a) begin void'(q_a.pop_front()); if (m_cnt_a < CNT_MAX) m_cnt_a++; end
            if (drain_b) begin void'(q_b.pop_front()); if (m_cnt_b < CNT_MAX) m_cnt_b++; end
            if (acc) begin
                if (s) q_b.push_back(d);
                else   q_a.push_back(d);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (rdy_obs !== 1'b1) begin
            failures++; $display("FAIL reset_inready: got %b want 1", rdy_obs);
        end
        assertions++;
        if ({outAValid, outBValid, outAData, outBData, cntA, cntB} !== '0) begin
            failures++;
            $display("FAIL reset_state: vA=%b vB=%b dA=%h dB=%h cA=%0d cB=%0d want all 0",
                     outAValid, outBValid, outAData, outBData, cntA, cntB);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (outAValid !== 1'b0 || outBValid !== 1'b0) begin
            failures++; $display("FAIL reset_discard: vA=%b vB=%b want 0 0", outAValid, outBValid);
        end
    endtask

    task automatic test_routing();
        do_reset();
        cycle(1'b0, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1);
        assertions++;
        if (outAValid !== 1'b1 || outAData !== 32'h11111111) begin
            failures++; $display("FAIL route_a: v=%b d=%h want 1 11111111", outAValid, outAData);
        end
        cycle(1'b0, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1);
        assertions++;
        if (outBValid !== 1'b1 || outBData !== 32'h22222222 || outAValid !== 1'b0) begin
            failures++;
            $display("FAIL route_b: vB=%b dB=%h vA=%b want 1 22222222 0", outBValid, outBData, outAValid);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        assertions++;
        if (cntA !== 4'd1 || cntB !== 4'd1) begin
            failures++; $display("FAIL route_counts: cA=%0d cB=%0d want 1 1", cntA, cntB);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b0, 32'hAAAA0001, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'hAAAA0002, 1'b0, 1'b1, 1'b0, 1'b1);
            assertions++;
            if (rdy_obs !== 1'b0 || outAValid !== 1'b1 || outAData !== 32'hAAAA0001) begin
                failures++;
                $display("FAIL stall_hold[%0d]: rdy=%b v=%b d=%h want 0 1 aaaa0001",
                         i, rdy_obs, outAValid, outAData);
            end
        end
        cycle(1'b0, 32'hAAAA0002, 1'b0, 1'b1, 1'b1, 1'b1);
        assertions++;
        if (rdy_obs !== 1'b1 || outAValid !== 1'b1 || outAData !== 32'hAAAA0002 || cntA !== 4'd1) begin
            failures++;
            $display("FAIL stall_release: rdy=%b v=%b d=%h cA=%0d want 1 1 aaaa0002 1",
                     rdy_obs, outAValid, outAData, cntA);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        assertions++;
        if (cntA !== 4'd2 || outAValid !== 1'b0) begin
            failures++; $display("FAIL stall_count: cA=%0d v=%b want 2 0", cntA, outAValid);
        end
    endtask

    task automatic test_unselected_stall();
        do_reset();
        cycle(1'b0, 32'hC0C0C0C0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'hBBBB0001, 1'b1, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (rdy_obs !== 1'b1 || outBValid !== 1'b1 || outBData !== 32'hBBBB0001 ||
            outAValid !== 1'b1 || outAData !== 32'hC0C0C0C0) begin
            failures++;
            $display("FAIL unselected_stall: rdy=%b vB=%b dB=%h vA=%b dA=%h want 1 1 bbbb0001 1 c0c0c0c0",
                     rdy_obs, outBValid, outBData, outAValid, outAData);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] words[8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            cycle(1'b0, words[i], 1'b1, 1'b1, 1'b1, 1'b1);
            assertions++;
            if (rdy_obs !== 1'b1 || outBValid !== 1'b1 || outBData !== words[i]) begin
                failures++;
                $display("FAIL b2b[%0d]: rdy=%b v=%b d=%h want 1 1 %h",
                         i, rdy_obs, outBValid, outBData, words[i]);
            end
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        assertions++;
        if (cntB !== 4'd8 || outBValid !== 1'b0) begin
            failures++; $display("FAIL b2b_count: cB=%0d v=%b want 8 0", cntB, outBValid);
        end
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        cycle(1'b0, 32'h0000000A, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0000000B, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000000C, 1'b0, 1'b1, 1'b1, 1'b1);
        assertions++;
        if ({outAValid, outBValid, outAData, outBData, cntA, cntB} !== '0) begin
            failures++;
            $display("FAIL reset_mid: vA=%b vB=%b dA=%h dB=%h cA=%0d cB=%0d want all 0",
                     outAValid, outBValid, outAData, outBData, cntA, cntB);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (outAValid !== 1'b0 || outBValid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_drop: vA=%b vB=%b want 0 0", outAValid, outBValid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b0, $urandom, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        assertions++;
        if (cntA !== 4'd15 || cntB !== 4'd0) begin
            failures++; $display("FAIL saturation: cA=%0d cB=%0d want 15 0", cntA, cntB);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom, 1'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 3) != 0);
            assertions++;
            if (rdy_obs !== rdy_exp) begin
                failures++; $display("FAIL random_ready[%0d]: got %b want %b", i, rdy_obs, rdy_exp);
            end
            assertions++;
            if (dut_snap() !== model_snap()) begin
                failures++;
                $display("FAIL random_state[%0d]: got %h want %h", i, dut_snap(), model_snap());
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_stall();
        test_unselected_stall();
        test_back_to_back();
        test_reset_mid_traffic();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
